dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised delay line built from enable-gated D flip-flop stages with synchronous active-high reset, per-stage valid tracking, stall and flush. Successor to the single-bit async-reset D flip-flop: generalises data width and depth, adds clock enable, bubble tracking and an occupancy count. Used wherever a datapath needs a fixed N-cycle registered delay that can stall or be discarded.

## Interface
Parameters:
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset; one clock, synchronous and active-high
- en  input  1  advance enable; 0 = stall, all stages hold
- flush  input  1  synchronous discard of all valid flags
- data  input  WIDTH  stage-0 data input
- data_valid  input  1  marks data as valid
- q  output  WIDTH  last-stage data
- q_valid  output  1  last-stage valid flag
- count  output  CNT_W  number of stages holding valid data, 0..DEPTH; CNT_W = clog2(DEPTH+1)

## Operation
- State: stage data d[0..DEPTH-1], valid flags v[0..DEPTH-1]; q = d[DEPTH-1], q_valid = v[DEPTH-1].
- Priority per edge: reset > flush > en > hold.
- reset=1: all d[i] <= RESET_VAL, all v[i] <= 0, count <= 0. en, flush, data ignored.
- flush=1 (reset=0): all v[i] <= 0, count <= 0; d[i] unchanged regardless of en; incoming data/data_valid discarded.
- en=1 (reset=0, flush=0): d[0] <= data, v[0] <= data_valid; d[i] <= d[i-1], v[i] <= v[i-1] for i ≥ 1. Data advances even when invalid (bubbles propagate).
- en=0: everything holds; data/data_valid ignored.
- count is a register, not a popcount: on en, count <= count + data_valid − v[DEPTH-1]; otherwise unchanged. Never exceeds DEPTH, never underflows.
- DEPTH=1: single stage; count is 1 bit.

## Timing
- Reset values: q = RESET_VAL, q_valid = 0, count = 0, from the first edge with reset=1.
- Latency: a word presented with en=1 at edge k appears on q after edge k+DEPTH-1 (visible cycle k+DEPTH) when en stays 1; each en=0 cycle adds one cycle.
- All outputs registered; no combinational path from inputs to outputs.
- reset mid-stream: all in-flight data lost on that edge; first post-reset valid word needs full DEPTH enabled edges.
- flush and en simultaneous: flush wins, no shift, valids cleared.
- Simultaneous entry and exit (data_valid=1, v[DEPTH-1]=1, en=1): count unchanged.

## Structure
- Sub-module dff_en_sreset: one WIDTH-bit stage with en and sync active-high reset to RESET_VAL; dff_pipe instantiates DEPTH of these via generate plus the valid chain and counter.
- Shared package dff_pkg: clog2 helper function and default constants (DEFAULT_WIDTH=8, DEFAULT_DEPTH=4); CNT_W derived locally from it.
- No FSM; valid chain and counter are plain registers in dff_pipe.

## Test plan
- Reset: reset=1 for 2 cycles with data=8'hFF, en=1 -> q=8'h00, q_valid=0, count=0 throughout and after release.
- Streaming: en=1, send 8'h11,22,33,44,55 valid on consecutive edges (DEPTH=4) -> q_valid rises 4 cycles after first entry; q = 11,22,33,44,55 in order; count ramps 1,2,3,4 and holds 4.
- Stall: mid-stream en=0 for 3 cycles with data=8'hAA valid -> q, q_valid, count frozen; 8'hAA not captured; stream resumes unchanged.
- Bubbles: send valid 8'h01, invalid, valid 8'h03 -> q_valid pattern 1,0,1 at output; count peaks at 2.
- Flush: with count=3, assert flush and en together with data_valid=1 -> next cycle count=0, q_valid=0, q unchanged; nothing valid exits for the next 4 enabled cycles.
- Reset mid-stream: with count=4, pulse reset one cycle -> q=RESET_VAL, count=0; next valid word exits after exactly 4 enabled edges.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe delay line.
package dff_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Number of bits needed to hold values 0..n-1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Data/control bundle between a producer and the dff_pipe delay line.
interface dff_pipe_if #(
    parameter int WIDTH = dff_pkg::DEFAULT_WIDTH,
    parameter int DEPTH = dff_pkg::DEFAULT_DEPTH
);
    localparam int CNT_W = dff_pkg::clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CNT_W-1:0] count;

    modport master (
        output en, flush, data, data_valid,
        input  q, q_valid, count
    );

    modport slave (
        input  en, flush, data, data_valid,
        output q, q_valid, count
    );

endinterface

// File: rtl/dff_en_sreset.sv
// One WIDTH-bit register stage with enable and sync active-high reset.
module dff_en_sreset #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff_pipe.sv
// Fixed-depth registered delay line with stall, flush, bubbles and occupancy.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic      clk,
    input  logic      reset,
    dff_pipe_if.slave bus
);

    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] w_q [DEPTH];
    logic [DEPTH-1:0] r_v;
    logic [CNT_W-1:0] r_cnt;
    logic             w_adv;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Flush freezes data stages; only the valid flags are cleared.
    assign w_adv = bus.en & ~bus.flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] w_in;
        if (i == 0) begin : g_first
            assign w_in = bus.data;
        end else begin : g_rest
            assign w_in = w_q[i-1];
        end
        dff_en_sreset #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_adv),
            .i_d   (w_in),
            .o_q   (w_q[i])
        );
    end

    assign w_cnt_nxt = r_cnt + CNT_W'(bus.data_valid)
                     - CNT_W'(r_v[DEPTH-1]);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_v   <= '0;
            r_cnt <= '0;
        end else if (bus.en) begin
            r_v   <= (r_v << 1) | DEPTH'(bus.data_valid);
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.q       = w_q[DEPTH-1];
    assign bus.q_valid = r_v[DEPTH-1];
    assign bus.count   = r_cnt;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe against a queue-based reference model.
module tb_dff_pipe;

    localparam int         W  = 8;
    localparam int         D  = 4;
    localparam logic [7:0] RV = 8'h00;

    logic clk;
    logic reset;

    dff_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

    dff_pipe #(
        .WIDTH     (W),
        .DEPTH     (D),
        .RESET_VAL (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } ent_t;

    ent_t m_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic int m_count();
        int c;
        c = 0;
        foreach (m_q[i]) if (m_q[i].v) c++;
        return c;
    endfunction

    // Reference: a DEPTH-long queue, newest at the front.
    function automatic void model_edge(input bit rst, input bit fl,
                                       input bit e, input bit dv,
                                       input logic [7:0] dat);
        ent_t n;
        if (rst) begin
            m_q.delete();
            n = {1'b0, RV};
            repeat (D) m_q.push_back(n);
        end else if (fl) begin
            foreach (m_q[i]) m_q[i].v = 1'b0;
        end else if (e) begin
            n = {dv, dat};
            m_q.push_front(n);
            void'(m_q.pop_back());
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"}, 32'(bus.q), 32'(m_q[D-1].d));
        check({tag, ".qv"}, 32'(bus.q_valid), 32'(m_q[D-1].v));
        check({tag, ".cnt"}, 32'(bus.count), 32'(m_count()));
    endtask

    task automatic step(input string tag, input bit rst, input bit fl,
                        input bit e, input bit dv, input logic [7:0] dat);
        reset          = rst;
        bus.flush      = fl;
        bus.en         = e;
        bus.data_valid = dv;
        bus.data       = dat;
        @(posedge clk);
        model_edge(rst, fl, e, dv, dat);
        #1;
        check_all(tag);
    endtask

    initial begin
        int lat;
        logic [7:0] seq [5];
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.en = 1'b0;
        bus.data_valid = 1'b0;
        bus.data = '0;
        #2;

        // Reset with garbage on the inputs.
        step("rst0", 1, 0, 1, 1, 8'hFF);
        step("rst1", 1, 0, 1, 1, 8'hFF);
        step("rel", 0, 0, 0, 0, 8'hFF);

        // Streaming.
        for (int i = 0; i < 5; i++) step("strm", 0, 0, 1, 1, seq[i]);
        check("cnt_full", 32'(bus.count), 32'd4);

        // Stall with a valid word offered.
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 1, 8'hAA);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 1, 0, 8'h00);
        check("empty", 32'(bus.count), 32'd0);

        // Bubbles.
        step("bub", 0, 0, 1, 1, 8'h01);
        step("bub", 0, 0, 1, 0, 8'h02);
        step("bub", 0, 0, 1, 1, 8'h03);
        for (int i = 0; i < 5; i++) step("bubd", 0, 0, 1, 0, 8'h00);

        // Flush with three valid words resident.
        for (int i = 0; i < 3; i++) step("fill", 0, 0, 1, 1, 8'hC0 + 8'(i));
        check("cnt3", 32'(bus.count), 32'd3);
        step("flush", 0, 1, 1, 1, 8'hEE);
        check("fl_cnt", 32'(bus.count), 32'd0);
        for (int i = 0; i < 4; i++) step("postfl", 0, 0, 1, 0, 8'h00);

        // Reset mid-stream, then measure latency of the next word.
        for (int i = 0; i < 4; i++) step("fill4", 0, 0, 1, 1, 8'hD0 + 8'(i));
        step("midrst", 1, 0, 1, 1, 8'h99);
        check("mr_q", 32'(bus.q), 32'(RV));
        step("lat0", 0, 0, 1, 1, 8'h5A);
        lat = 1;
        while (!bus.q_valid && lat < 12) begin
            step("latn", 0, 0, 1, 0, 8'h00);
            lat++;
        end
        check("latency", 32'(lat), 32'(D));
        check("lat_q", 32'(bus.q), 32'h5A);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 1),
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
